// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Width needed to index n items; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick,
  output logic               any
);

  always_comb begin
    int unsigned idx;
    idx  = 0;
    pick = '0;
    any  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the fifo_mem write port among NUM_REQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          gnt_vld,
  output logic [clog2(NUM_REQ)-1:0]     gnt_id,
  output logic                          busy
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(MAX_BURST + 1);

  arb_state_e             state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       pick;
  logic                   any;
  logic [IDX_W-1:0]       nxt_ptr;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   out_vld;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   can_load;
  logic                   own_valid;
  logic                   own_last;
  logic [DATA_WIDTH-1:0]  own_data;
  logic                   xfer;
  logic                   last_beat;
  logic                   burst_done;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req  (req_valid),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // Owner's lane, selected by the registered grant index.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDX_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == ARB_BURST) && (gnt_id == IDX_W'(i)) && can_load;
    end
  end

  assign can_load  = ~out_vld | ~wfull;
  assign winc      = out_vld & ~wfull;
  assign wdata     = out_data;
  assign busy      = gnt_vld | out_vld;
  assign xfer      = (state == ARB_BURST) && own_valid && can_load;
  assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign nxt_ptr   = (gnt_id == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  // An idle owner only releases the port once the output stage could accept,
  // so a full FIFO never strands a burst half-way.
  assign burst_done = (state == ARB_BURST) &&
                      (xfer ? (own_last || last_beat) : (!own_valid && can_load));

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= ARB_IDLE;
      gnt_vld  <= 1'b0;
      gnt_id   <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any) begin
            gnt_id   <= pick;
            gnt_vld  <= 1'b1;
            beat_cnt <= '0;
            state    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          if (burst_done) begin
            state   <= ARB_IDLE;
            gnt_vld <= 1'b0;
            ptr     <= nxt_ptr;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (xfer) begin
      out_vld  <= 1'b1;
      out_data <= own_data;
    end else if (winc) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a cycle table plus scoreboarded multi-cycle sequences.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned MB = 8;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            wfull;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic            gnt_vld;
  logic [1:0]      gnt_id;
  logic            busy;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic        full;
    logic [31:0] word;
    logic [3:0]  e_ready;
    logic        e_winc;
    logic [31:0] e_wdata;
    logic        e_gvld;
    logic [1:0]  e_gid;
    logic        e_busy;
  } vec_t;

  vec_t vecs[11];

  // Scoreboard-sequence state
  int unsigned n_words[NR];
  int unsigned sent[NR];
  int          last_at[NR];
  int unsigned inj_add[NR];
  int          inj_cyc;
  logic [31:0] sb[$];
  int          grant_log[$];
  int          grant_cyc[$];
  int          gv_cycles;

  function automatic logic [31:0] word_of(input int i, input int unsigned k);
    return 32'hC000_0000 | (32'(i) << 16) | k;
  endfunction

  task automatic do_reset();
    wrst_n    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (sent[i] < n_words[i]);
      req_last[i]  = req_valid[i] && (int'(sent[i]) == last_at[i]);
      req_data[i*DW +: DW] = word_of(i, sent[i]);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NR; i++) begin
      n_words[i] = 0; sent[i] = 0; last_at[i] = -1; inj_add[i] = 0;
    end
    inj_cyc = -1;
    sb.delete();
    grant_log.delete();
    grant_cyc.delete();
    gv_cycles = 0;
  endtask

  // toggle=1: wfull high on odd cycles; otherwise high in [full_lo, full_hi].
  task automatic run_seq(input string tag, input int full_lo, input int full_hi,
                         input bit toggle, input int max_cyc);
    logic        prev_gvld;
    logic [31:0] held;
    int unsigned tot_sent, tot_words;
    prev_gvld = 1'b0;
    held      = '0;
    do_reset();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge wclk);
      if (c == inj_cyc)
        for (int i = 0; i < NR; i++) n_words[i] += inj_add[i];
      wfull = toggle ? c[0] : (c >= full_lo && c <= full_hi);
      drive_sources();
      #2;
      if (wfull) chk({tag, "_winc_when_full"}, 32'(winc), 32'd0);
      if (!toggle && wfull) begin
        chk({tag, "_ready_when_full"}, 32'(req_ready), 32'd0);
        if (c == full_lo) held = wdata;
        else chk({tag, "_wdata_stable"}, wdata, held);
      end
      if (winc) begin
        if (sb.size() == 0) chk({tag, "_unexpected_write"}, wdata, 32'hDEAD_DEAD);
        else chk({tag, "_wdata"}, wdata, sb.pop_front());
      end
      if (!prev_gvld && gnt_vld) begin
        grant_log.push_back(int'(gnt_id));
        grant_cyc.push_back(c);
      end
      if (gnt_vld) gv_cycles++;
      prev_gvld = gnt_vld;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(word_of(i, sent[i]));
          sent[i]++;
        end
      end
    end
    tot_sent = 0; tot_words = 0;
    for (int i = 0; i < NR; i++) begin
      tot_sent += sent[i]; tot_words += n_words[i];
    end
    chk({tag, "_all_sent"}, tot_sent, tot_words);
    chk({tag, "_all_written"}, 32'(sb.size()), 32'd0);
    chk({tag, "_idle_at_end"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_grants(input string tag, input int exp_q[$]);
    chk({tag, "_grant_count"}, 32'(grant_log.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < grant_log.size(); k++)
      chk($sformatf("%s_grant%0d", tag, k), 32'(grant_log[k]), 32'(exp_q[k]));
  endtask

  initial begin
    //            vld     last    f  word          ready   wi wdata         gv gid bsy
    vecs[0]  = '{4'b0001, 4'b0000, 0, 32'h0000_0D00, 4'b0000, 0, 32'h0,         0, 0, 0};
    vecs[1]  = '{4'b0001, 4'b0000, 0, 32'h0000_0D00, 4'b0001, 0, 32'h0,         1, 0, 1};
    vecs[2]  = '{4'b0001, 4'b0000, 0, 32'h0000_0D01, 4'b0001, 1, 32'h0000_0D00, 1, 0, 1};
    vecs[3]  = '{4'b0001, 4'b0001, 0, 32'h0000_0D02, 4'b0001, 1, 32'h0000_0D01, 1, 0, 1};
    vecs[4]  = '{4'b0000, 4'b0000, 0, 32'h0000_0D02, 4'b0000, 1, 32'h0000_0D02, 0, 0, 1};
    vecs[5]  = '{4'b0000, 4'b0000, 0, 32'h0000_0D02, 4'b0000, 0, 32'h0000_0D02, 0, 0, 0};
    vecs[6]  = '{4'b0011, 4'b0000, 0, 32'h0000_0D03, 4'b0000, 0, 32'h0000_0D02, 0, 0, 0};
    vecs[7]  = '{4'b0011, 4'b0010, 0, 32'h0000_0D03, 4'b0010, 0, 32'h0000_0D02, 1, 1, 1};
    vecs[8]  = '{4'b0001, 4'b0000, 0, 32'h0000_0D03, 4'b0000, 1, 32'h1000_0D03, 0, 1, 1};
    vecs[9]  = '{4'b0000, 4'b0000, 0, 32'h0000_0D03, 4'b0001, 0, 32'h1000_0D03, 1, 0, 1};
    vecs[10] = '{4'b0000, 4'b0000, 0, 32'h0000_0D03, 4'b0000, 0, 32'h1000_0D03, 0, 0, 0};

    // Reset state
    do_reset();
    #2;
    chk("rst_winc",    32'(winc),      32'd0);
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_gnt_vld", 32'(gnt_vld),   32'd0);
    chk("rst_gnt_id",  32'(gnt_id),    32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_wdata",   wdata,          32'd0);

    // Cycle table: 3-word burst from req 0, then pointer-driven pick of req 1,
    // then req 0 granted and dropping valid without a transfer.
    for (int r = 0; r < 11; r++) begin
      @(negedge wclk);
      req_valid = vecs[r].vld;
      req_last  = vecs[r].last;
      wfull     = vecs[r].full;
      for (int i = 0; i < NR; i++)
        req_data[i*DW +: DW] = vecs[r].word ^ (32'(i) << 28);
      #2;
      chk($sformatf("row%0d_ready", r),   32'(req_ready), 32'(vecs[r].e_ready));
      chk($sformatf("row%0d_winc", r),    32'(winc),      32'(vecs[r].e_winc));
      chk($sformatf("row%0d_wdata", r),   wdata,          vecs[r].e_wdata);
      chk($sformatf("row%0d_gnt_vld", r), 32'(gnt_vld),   32'(vecs[r].e_gvld));
      chk($sformatf("row%0d_gnt_id", r),  32'(gnt_id),    32'(vecs[r].e_gid));
      chk($sformatf("row%0d_busy", r),    32'(busy),      32'(vecs[r].e_busy));
    end

    // All requesters busy: bursts capped at MAX_BURST, order 0,1,2,3,0, one bubble each.
    clear_cfg();
    n_words[0] = 16; n_words[1] = 8; n_words[2] = 8; n_words[3] = 8;
    run_seq("rr4", -1, -1, 1'b0, 60);
    chk_grants("rr4", '{0, 1, 2, 3, 0});
    chk("rr4_gnt_cycles", 32'(gv_cycles), 32'd40);
    for (int k = 1; k < grant_cyc.size(); k++)
      chk($sformatf("rr4_spacing%0d", k), 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd9);

    // Req 2 stalled by 5 cycles of wfull mid-burst.
    clear_cfg();
    n_words[2] = 6; last_at[2] = 5;
    run_seq("stall", 3, 7, 1'b0, 20);
    chk_grants("stall", '{2});

    // Req 1 drops valid early; req 3 next; req 1 re-raises and waits behind req 0.
    clear_cfg();
    n_words[1] = 2; n_words[3] = 3; last_at[3] = 2;
    inj_cyc = 6; inj_add[0] = 2; inj_add[1] = 2;
    run_seq("drop", -1, -1, 1'b0, 25);
    chk_grants("drop", '{1, 3, 0, 1});

    // wfull toggling: 10 words from req 0 split 8 + 2 by the burst cap.
    clear_cfg();
    n_words[0] = 10;
    run_seq("toggle", -1, -1, 1'b1, 45);
    chk_grants("toggle", '{0, 0});

    // Asynchronous reset during a burst with a word in the output stage.
    clear_cfg();
    do_reset();
    @(negedge wclk);
    req_valid = 4'b0010; req_last = 4'b0010; req_data[1*DW +: DW] = 32'h1111_0001;
    @(negedge wclk);
    @(negedge wclk);
    req_valid = 4'b0100; req_last = 4'b0000; req_data[2*DW +: DW] = 32'h2222_0000;
    @(negedge wclk);
    @(negedge wclk);
    req_data[2*DW +: DW] = 32'h2222_0001;
    #2;
    chk("mrst_pre_winc",   32'(winc),    32'd1);
    chk("mrst_pre_wdata",  wdata,        32'h2222_0000);
    chk("mrst_pre_gnt_id", 32'(gnt_id),  32'd2);
    #1 wrst_n = 1'b0;
    #1;
    chk("mrst_winc",    32'(winc),      32'd0);
    chk("mrst_ready",   32'(req_ready), 32'd0);
    chk("mrst_gnt_vld", 32'(gnt_vld),   32'd0);
    chk("mrst_busy",    32'(busy),      32'd0);
    chk("mrst_wdata",   wdata,          32'd0);
    req_valid = 4'b1001; req_last = 4'b0000;
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    @(negedge wclk);
    #2;
    chk("mrst_regrant_vld", 32'(gnt_vld), 32'd1);
    chk("mrst_regrant_id",  32'(gnt_id),  32'd0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
